lc3_mem_responder: RTL and testbench

- Memory-side responder for the LC-3 memory interface.
- Datapath initiates accesses by presenting MAR on addr and MDR on data_in.
- This block holds the word-addressed program/data RAM.
- It completes each read or write after a fixed programmable latency, returns read data on data_out and pulses mem_rdy so the control FSM can load MDR.
- A backdoor load port lets the bench/boot logic preload programs.

---
 rtl/lc3_mem_responder_if.sv | 41 ++++
 rtl/lc3_mem_responder.sv | 157 +++++++++++++++
 tb/tb_lc3_mem_responder.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_mem_responder_if.sv
// ---------------------------------------------------------------------------
// lc3_mem_responder_if
// Bundles the LC-3 memory request/response signals and the backdoor load
// port between the datapath (master) and the memory responder (slave).
//
// Signals:
//   mem_en   request strobe            (master -> slave)
//   mem_we   1=write, 0=read           (master -> slave)
//   addr     word address (MAR)        (master -> slave)
//   data_in  write data (MDR)          (master -> slave)
//   ld_en    backdoor write strobe     (master -> slave)
//   ld_addr  backdoor address          (master -> slave)
//   ld_data  backdoor data             (master -> slave)
//   data_out read data                 (slave -> master)
//   mem_rdy  one-cycle completion      (slave -> master)
//   busy     request in flight         (slave -> master)
//   err      out-of-range pulse        (slave -> master)
// ---------------------------------------------------------------------------
interface lc3_mem_responder_if;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        mem_rdy;
    logic        busy;
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;
    logic        err;

    modport master (
        output mem_en, mem_we, addr, data_in, ld_en, ld_addr, ld_data,
        input  data_out, mem_rdy, busy, err
    );

    modport slave (
        input  mem_en, mem_we, addr, data_in, ld_en, ld_addr, ld_data,
        output data_out, mem_rdy, busy, err
    );
endinterface

// File: rtl/lc3_mem_responder.sv
// ---------------------------------------------------------------------------
// lc3_mem_responder
// Memory-side responder for the LC-3 memory interface. Holds the word-
// addressed program/data RAM, completes each read or write a fixed LATENCY
// cycles after acceptance and pulses mem_rdy for one cycle. A backdoor port
// preloads RAM in any state.
//
// Ports:
//   i_clk   system clock, rising edge
//   i_rst   synchronous active-low reset
//   io_mem  lc3_mem_responder_if.slave (request, response, backdoor, err)
//
// Parameters:
//   DEPTH    number of 16-bit words, power of two, 2..65536
//   LATENCY  acceptance-to-mem_rdy cycles, 1..15
//
// Build option:
//   MEM_RANGE_CHECK_EN  when defined, addresses >= DEPTH do not wrap:
//                       writes are dropped, reads return 16'hDEAD, err
//                       pulses with mem_rdy, out-of-range backdoor loads
//                       are dropped. When undefined, addresses wrap and
//                       err stays 0.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for mem_en; mem_rdy may be high for the prior access
// S_BUSY | request captured, counting down to completion
// ---------------------------------------------------------------------------
module lc3_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    lc3_mem_responder_if.slave   io_mem
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] RD_POISON = 16'hDEAD;
    localparam logic [15:0] IDX_MASK  = 16'(DEPTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_nxt;
    logic          w_accept;
    logic          w_done;

    logic [15:0]   r_addr;
    logic [15:0]   r_wdata;
    logic          r_we;
    logic [15:0]   r_data_out;
    logic          r_mem_rdy;
    logic          r_err;

    logic [15:0]   r_mem [DEPTH];

    logic [AW-1:0] w_idx;
    logic [AW-1:0] w_ld_idx;
    logic          w_oor;
    logic          w_ld_ok;
    logic          w_unused_addr_hi;

    assign w_idx    = r_addr[AW-1:0];
    assign w_ld_idx = io_mem.ld_addr[AW-1:0];

`ifdef MEM_RANGE_CHECK_EN
    assign w_oor   = ({1'b0, r_addr} >= 17'(DEPTH));
    assign w_ld_ok = ({1'b0, io_mem.ld_addr} < 17'(DEPTH));
`else
    assign w_oor   = 1'b0;
    assign w_ld_ok = 1'b1;
`endif

    // Upper address bits only matter for the range check; fold them here so
    // the wrapping build does not leave them dangling.
    assign w_unused_addr_hi = ^{r_addr & ~IDX_MASK, io_mem.ld_addr & ~IDX_MASK};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_mem.mem_en) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = 4'(LATENCY - 1);
                end
            end
            S_BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_data_out <= 16'h0000;
            r_mem_rdy  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_mem_rdy <= w_done;
            r_err     <= w_done & w_oor;
            // RAM read samples the pre-edge contents, so a coincident
            // backdoor write to the same word is not visible here.
            if (w_done && !r_we) begin
                r_data_out <= w_oor ? RD_POISON : r_mem[w_idx];
            end
        end
    end

    // Request capture needs no reset: it is only consumed after acceptance.
    always_ff @(posedge i_clk) begin
        if (i_rst && w_accept) begin
            r_addr  <= io_mem.addr;
            r_wdata <= io_mem.data_in;
            r_we    <= io_mem.mem_we;
        end
    end

    // RAM is never cleared. The functional write is placed last so it wins
    // over a backdoor write to the same word on the same edge; reset blocks
    // the functional commit so an aborted write leaves RAM untouched.
    always_ff @(posedge i_clk) begin
        if (io_mem.ld_en && w_ld_ok) begin
            r_mem[w_ld_idx] <= io_mem.ld_data;
        end
        if (i_rst && w_done && r_we && !w_oor) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    assign io_mem.data_out = r_data_out;
    assign io_mem.mem_rdy  = r_mem_rdy;
    assign io_mem.busy     = (r_state == S_BUSY);
    assign io_mem.err      = r_err;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_lc3_mem_responder
// Directed test of lc3_mem_responder (DEPTH=1024, LATENCY=2). A transaction
// level model tracks each request by its due cycle and a sparse RAM image;
// a checker compares busy/mem_rdy/err/data_out against it every cycle.
// Build option MEM_RANGE_CHECK_EN is mirrored by the model and the literal
// expectations.
// ---------------------------------------------------------------------------
module tb_lc3_mem_responder;

    localparam int          DEPTH  = 1024;
    localparam int          LAT    = 2;
    localparam logic [15:0] POISON = 16'hDEAD;
`ifdef MEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lc3_mem_responder_if bus ();

    lc3_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_mem (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int          cyc = 0;
    bit          m_valid = 1'b0;
    bit          m_busy  = 1'b0;
    int          m_due;
    bit          m_we;
    logic [15:0] m_a;
    logic [15:0] m_d;
    logic [15:0] m_mem [int];
    logic [15:0] e_dout;
    bit          e_known = 1'b0;
    bit          e_rdy   = 1'b0;
    bit          e_err   = 1'b0;

    always @(posedge clk) begin
        bit oor;
        bit do_wr;
        int ix;
        e_rdy = 1'b0;
        e_err = 1'b0;
        do_wr = 1'b0;
        ix    = 0;
        if (!rst) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            e_dout  = 16'h0000;
            e_known = 1'b1;
        end else if (m_busy && cyc == m_due) begin
            m_busy = 1'b0;
            e_rdy  = 1'b1;
            oor    = RC && (int'(m_a) >= DEPTH);
            e_err  = oor;
            ix     = int'(m_a) % DEPTH;
            if (m_we) begin
                do_wr = !oor;
            end else if (oor) begin
                e_dout  = POISON;
                e_known = 1'b1;
            end else if (m_mem.exists(ix)) begin
                e_dout  = m_mem[ix];
                e_known = 1'b1;
            end else begin
                e_known = 1'b0;
            end
        end else if (!m_busy && bus.mem_en) begin
            m_busy = 1'b1;
            m_due  = cyc + LAT;
            m_we   = bus.mem_we;
            m_a    = bus.addr;
            m_d    = bus.data_in;
        end
        if (bus.ld_en && !(RC && int'(bus.ld_addr) >= DEPTH))
            m_mem[int'(bus.ld_addr) % DEPTH] = bus.ld_data;
        if (do_wr)
            m_mem[ix] = m_d;
        cyc++;
    end

    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            check16("busy", {15'b0, bus.busy}, {15'b0, m_busy});
            check16("mem_rdy", {15'b0, bus.mem_rdy}, {15'b0, e_rdy});
            check16("err", {15'b0, bus.err}, {15'b0, e_err});
            if (e_known)
                check16("data_out", bus.data_out, e_dout);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic bd(input logic [15:0] a, input logic [15:0] d);
        bus.ld_en   = 1'b1;
        bus.ld_addr = a;
        bus.ld_data = d;
        @(negedge clk);
        bus.ld_en   = 1'b0;
    endtask

    // Issues one request; optionally fires a backdoor write on the completion
    // edge. Returns the number of cycles until mem_rdy was seen.
    task automatic req(input bit we, input logic [15:0] a, input logic [15:0] d,
                       input bit ld_on, input logic [15:0] la, input logic [15:0] ldd,
                       output int lat);
        bus.mem_en  = 1'b1;
        bus.mem_we  = we;
        bus.addr    = a;
        bus.data_in = d;
        @(negedge clk);
        bus.mem_en  = 1'b0;
        lat = 0;
        while (!bus.mem_rdy && lat < 20) begin
            if (ld_on && lat == LAT - 1) begin
                bus.ld_en   = 1'b1;
                bus.ld_addr = la;
                bus.ld_data = ldd;
            end else begin
                bus.ld_en = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.ld_en = 1'b0;
        if (lat >= 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout: no mem_rdy within %0d cycles, required %0d", lat, LAT);
        end
    endtask

    task automatic rd(input logic [15:0] a, output int lat);
        req(1'b0, a, 16'h0000, 1'b0, 16'h0, 16'h0, lat);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d, output int lat);
        req(1'b1, a, d, 1'b0, 16'h0, 16'h0, lat);
    endtask

    initial begin
        int lat;
        int cnt;

        // Reset with a pending request strobe.
        bus.mem_en  = 1'b1;
        bus.mem_we  = 1'b1;
        bus.addr    = 16'h0005;
        bus.data_in = 16'hFFFF;
        bus.ld_en   = 1'b0;
        bus.ld_addr = 16'h0;
        bus.ld_data = 16'h0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check16("rst_busy", {15'b0, bus.busy}, 16'h0);
        check16("rst_rdy", {15'b0, bus.mem_rdy}, 16'h0);
        check16("rst_dout", bus.data_out, 16'h0000);
        bus.mem_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // Backdoor then read.
        bd(16'h3000, 16'h1234);
        rd(16'h3000, lat);
        check16("rd_latency", 16'(lat), 16'(LAT));
        check16("rd_3000", bus.data_out, RC ? POISON : 16'h1234);

        // Write then back-to-back read, data_out holds over a later write.
        wr(16'h0010, 16'hBEEF, lat);
        check16("wr_latency", 16'(lat), 16'(LAT));
        rd(16'h0010, lat);
        check16("b2b_latency", 16'(lat), 16'(LAT));
        check16("rd_0010", bus.data_out, 16'hBEEF);
        wr(16'h0011, 16'h1111, lat);
        check16("dout_hold", bus.data_out, 16'hBEEF);

        // Request during BUSY is dropped.
        bd(16'h0020, 16'h7777);
        bus.mem_en  = 1'b1;
        bus.mem_we  = 1'b1;
        bus.addr    = 16'h0030;
        bus.data_in = 16'hCAFE;
        @(negedge clk);
        bus.addr    = 16'h0020;
        bus.data_in = 16'h9999;
        @(negedge clk);
        bus.mem_en  = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.mem_rdy) cnt++;
            @(negedge clk);
        end
        check16("busy_drop_pulses", 16'(cnt), 16'd1);
        rd(16'h0020, lat);
        check16("busy_drop_ram", bus.data_out, 16'h7777);
        rd(16'h0030, lat);
        check16("busy_first_wr", bus.data_out, 16'hCAFE);

        // Reset on the completion edge aborts the write.
        bd(16'h0005, 16'h5555);
        bus.mem_en  = 1'b1;
        bus.mem_we  = 1'b1;
        bus.addr    = 16'h0005;
        bus.data_in = 16'hAAAA;
        @(negedge clk);
        bus.mem_en  = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.mem_rdy) cnt++;
            @(negedge clk);
        end
        check16("abort_pulses", 16'(cnt), 16'd0);
        rd(16'h0005, lat);
        check16("abort_ram", bus.data_out, 16'h5555);

        // Wrap / range check.
        bd(16'h0005, 16'h00FF);
        rd(16'h0405, lat);
        check16("wrap_dout", bus.data_out, RC ? POISON : 16'h00FF);
        check16("wrap_err", {15'b0, bus.err}, RC ? 16'd1 : 16'd0);
        @(negedge clk);
        check16("err_one_cycle", {15'b0, bus.err}, 16'd0);

        // Backdoor collisions: functional write wins, read sees old value.
        req(1'b1, 16'h0040, 16'h4242, 1'b1, 16'h0040, 16'h1313, lat);
        rd(16'h0040, lat);
        check16("coll_wr_wins", bus.data_out, 16'h4242);
        bd(16'h0041, 16'h0101);
        req(1'b0, 16'h0041, 16'h0000, 1'b1, 16'h0041, 16'h0202, lat);
        check16("coll_rd_old", bus.data_out, 16'h0101);
        rd(16'h0041, lat);
        check16("coll_rd_new", bus.data_out, 16'h0202);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
